call_register: RTL and testbench

Parametrised call-latching register for the N-floor, two-way elevator controller. It edge-detects hall (up/down) and car buttons and holds each as a pending call. A call clears when the car serves that floor with the door open and the car stopped. It also reports above/below/here summaries to the motion controller. This block sits between the button inputs and the direction/motion state machine.

---
 rtl/elevator_pkg.sv | 20 ++
 rtl/press_edge.sv | 25 ++
 rtl/call_register.sv | 132 +++++++++++++
 tb/tb_call_register.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator definitions: direction codes, door/motion levels and the
// floor-numbering rule (floor k lives at bit k-1 of every floor vector).
package elevator_pkg;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam logic OPEN  = 1'b1;
  localparam logic CLOSE = 1'b0;
  localparam logic MOVE  = 1'b1;
  localparam logic HOLD  = 1'b0;

  function automatic int floor_to_bit(input int floor);
    return floor - 32'sd1;
  endfunction

endpackage

// File: rtl/press_edge.sv
// Registered rising-edge detector: press goes high for one cycle, one clock
// after a 0->1 transition of btn relative to its previous sampled value.
module press_edge #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] prev_r;

  // Button history and registered edge pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= {W{1'b0}};
      press  <= {W{1'b0}};
    end else begin
      prev_r <= btn;
      press  <= btn & ~prev_r;
    end
  end

endmodule

// File: rtl/call_register.sv
// Latches hall/car button presses as pending calls, clears them on service and
// summarises calls relative to the car. Define CALL_CANCEL_EN for car-call cancel.
module call_register
  import elevator_pkg::*;
#(
  parameter int FLOORS  = 7,
  parameter int FLOOR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  hall_up_btn,
  input  logic [FLOORS-1:0]  hall_dn_btn,
  input  logic [FLOORS-1:0]  car_btn,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic [1:0]         current_direction,
  input  logic               door_open,
  input  logic               moving,
  output logic [FLOORS-1:0]  hall_up_call,
  output logic [FLOORS-1:0]  hall_dn_call,
  output logic [FLOORS-1:0]  car_call,
  output logic               call_above,
  output logic               call_below,
  output logic               call_here,
  output logic               serviced
);

  // Top floor has no up button, bottom floor has no down button.
  localparam logic [FLOORS-1:0] UP_MASK = {OFF, {(FLOORS-1){ON}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){ON}}, OFF};

  logic [FLOORS-1:0] hu_press_s, hd_press_s, car_press_s;
  logic [FLOORS-1:0] floor_oh_s, above_s, below_s, any_call_s;
  logic [FLOORS-1:0] clr_up_s, clr_dn_s, clr_car_s, cancel_s;
  logic [FLOORS-1:0] hu_next_s, hd_next_s, car_next_s;
  logic              floor_ok_s, service_s, serviced_next_s;

  press_edge #(.W(FLOORS)) u_hu_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (hall_up_btn),
    .press (hu_press_s)
  );

  press_edge #(.W(FLOORS)) u_hd_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (hall_dn_btn),
    .press (hd_press_s)
  );

  press_edge #(.W(FLOORS)) u_car_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (car_btn),
    .press (car_press_s)
  );

  // Floor decode: one-hot position plus above/below masks, empty when out of range
  always_comb begin
    floor_ok_s = (int'(current_floor) >= 32'sd1) && (int'(current_floor) <= FLOORS);
    floor_oh_s = {FLOORS{1'b0}};
    above_s    = {FLOORS{1'b0}};
    below_s    = {FLOORS{1'b0}};
    for (int i = 0; i < FLOORS; i++) begin
      floor_oh_s[i] = floor_ok_s && (i == floor_to_bit(int'(current_floor)));
      above_s[i]    = floor_ok_s && (i >  floor_to_bit(int'(current_floor)));
      below_s[i]    = floor_ok_s && (i <  floor_to_bit(int'(current_floor)));
    end
  end

  assign any_call_s = hall_up_call | hall_dn_call | car_call;
  assign call_above = |(any_call_s & above_s);
  assign call_below = |(any_call_s & below_s);
  assign call_here  = |(any_call_s & floor_oh_s);

  // Service clears: car call always, hall calls by travel direction
  always_comb begin
    service_s = floor_ok_s && (door_open == OPEN) && (moving == HOLD);
    clr_up_s  = {FLOORS{1'b0}};
    clr_dn_s  = {FLOORS{1'b0}};
    clr_car_s = {FLOORS{1'b0}};
    if (service_s) begin
      clr_car_s = floor_oh_s;
      case (current_direction)
        DIR_UP:   clr_up_s = floor_oh_s;
        DIR_DN:   clr_dn_s = floor_oh_s;
        DIR_IDLE: begin
          clr_up_s = floor_oh_s;
          clr_dn_s = floor_oh_s;
        end
        default: begin
          clr_up_s = {FLOORS{1'b0}};
          clr_dn_s = {FLOORS{1'b0}};
        end
      endcase
    end else begin
      clr_car_s = {FLOORS{1'b0}};
    end
  end

`ifdef CALL_CANCEL_EN
  assign cancel_s = car_press_s & car_call;
`else
  assign cancel_s = {FLOORS{1'b0}};
`endif

  // Clear dominates a same-cycle press; cancels never count as service
  always_comb begin
    hu_next_s       = (hall_up_call | hu_press_s) & ~clr_up_s & UP_MASK;
    hd_next_s       = (hall_dn_call | hd_press_s) & ~clr_dn_s & DN_MASK;
    car_next_s      = (car_call | car_press_s) & ~(clr_car_s | cancel_s);
    serviced_next_s = |((hall_up_call & clr_up_s) |
                        (hall_dn_call & clr_dn_s) |
                        (car_call & clr_car_s));
  end

  // Call registers and service pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      hall_up_call <= {FLOORS{1'b0}};
      hall_dn_call <= {FLOORS{1'b0}};
      car_call     <= {FLOORS{1'b0}};
      serviced     <= 1'b0;
    end else begin
      hall_up_call <= hu_next_s;
      hall_dn_call <= hd_next_s;
      car_call     <= car_next_s;
      serviced     <= serviced_next_s;
    end
  end

endmodule

// File: tb/tb_call_register.sv
// Directed bench for call_register (FLOORS=7) with hand-computed expectations.
module tb_call_register;
  import elevator_pkg::*;

  localparam int FLOORS  = 7;
  localparam int FLOOR_W = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [FLOORS-1:0]  hall_up_btn, hall_dn_btn, car_btn;
  logic [FLOOR_W-1:0] current_floor;
  logic [1:0]         current_direction;
  logic               door_open, moving;
  logic [FLOORS-1:0]  hall_up_call, hall_dn_call, car_call;
  logic               call_above, call_below, call_here, serviced;
  logic [FLOORS-1:0]  cancel_exp;

  int total = 0;
  int bad   = 0;

  call_register #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .hall_up_btn       (hall_up_btn),
    .hall_dn_btn       (hall_dn_btn),
    .car_btn           (car_btn),
    .current_floor     (current_floor),
    .current_direction (current_direction),
    .door_open         (door_open),
    .moving            (moving),
    .hall_up_call      (hall_up_call),
    .hall_dn_call      (hall_dn_call),
    .car_call          (car_call),
    .call_above        (call_above),
    .call_below        (call_below),
    .call_here         (call_here),
    .serviced          (serviced)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    hall_up_btn = 7'b0; hall_dn_btn = 7'b0; car_btn = 7'b0;
    current_floor = 3'd1; current_direction = DIR_IDLE;
    door_open = 1'b0; moving = 1'b0;
    step(); step();
    chk("rst_car", 32'(car_call), 32'h0);
    chk("rst_hu", 32'(hall_up_call), 32'h0);
    chk("rst_hd", 32'(hall_dn_call), 32'h0);
    chk("rst_svc", 32'(serviced), 32'h0);
    chk("rst_above", 32'(call_above), 32'h0);
    reset = 1'b0;

    // car call at floor 3, then summaries and idle service
    car_btn = 7'b0000100; step();
    chk("press_lat", 32'(car_call), 32'h0);
    car_btn = 7'b0; step();
    chk("press_car", 32'(car_call), 32'h04);
    chk("above_f1", 32'(call_above), 32'h1);
    chk("below_f1", 32'(call_below), 32'h0);
    current_floor = 3'd3; #1;
    chk("here_f3", 32'(call_here), 32'h1);
    chk("above_f3", 32'(call_above), 32'h0);
    current_floor = 3'd5; #1;
    chk("below_f5", 32'(call_below), 32'h1);
    current_floor = 3'd3; door_open = 1'b1; step();
    chk("svc_car_clr", 32'(car_call), 32'h0);
    chk("svc_car_pulse", 32'(serviced), 32'h1);
    door_open = 1'b0; step();
    chk("svc_car_drop", 32'(serviced), 32'h0);

    // hall up at floor 5 served going up; pulse lasts one cycle
    hall_up_btn = 7'b0010000; step(); hall_up_btn = 7'b0; step();
    chk("hu_latch", 32'(hall_up_call), 32'h10);
    current_floor = 3'd5; current_direction = DIR_UP; door_open = 1'b1; step();
    chk("hu_up_clr", 32'(hall_up_call), 32'h0);
    chk("svc_up", 32'(serviced), 32'h1);
    step();
    chk("svc_once", 32'(serviced), 32'h0);
    door_open = 1'b0;

    // same call while heading down is not served
    hall_up_btn = 7'b0010000; step(); hall_up_btn = 7'b0; step();
    chk("hu_relatch", 32'(hall_up_call), 32'h10);
    current_direction = DIR_DN; door_open = 1'b1; step();
    chk("hu_dn_keep", 32'(hall_up_call), 32'h10);
    chk("svc_dn", 32'(serviced), 32'h0);
    chk("here_f5", 32'(call_here), 32'h1);
    current_direction = DIR_UP; step();
    chk("hu_up_clr2", 32'(hall_up_call), 32'h0);
    door_open = 1'b0; step();

    // hardwired-zero bits
    hall_up_btn = 7'b1000000; hall_dn_btn = 7'b1000001; step();
    hall_up_btn = 7'b0; hall_dn_btn = 7'b0; step();
    chk("hu_top_zero", 32'(hall_up_call), 32'h0);
    chk("hd_bot_zero", 32'(hall_dn_call), 32'h40);
    chk("above_hd", 32'(call_above), 32'h1);

    // illegal door open while moving, then invalid floor
    car_btn = 7'b0000100; step(); car_btn = 7'b0; step();
    current_floor = 3'd3; door_open = 1'b1; moving = 1'b1; step();
    chk("illegal_keep", 32'(car_call), 32'h04);
    chk("illegal_svc", 32'(serviced), 32'h0);
    door_open = 1'b0; moving = 1'b0; current_floor = 3'd0; #1;
    chk("above_f0", 32'(call_above), 32'h0);
    chk("below_f0", 32'(call_below), 32'h0);
    chk("here_f0", 32'(call_here), 32'h0);

    // press at the floor being served is absorbed
    current_floor = 3'd4; current_direction = DIR_IDLE; door_open = 1'b1;
    car_btn = 7'b0001000; step(); step();
    chk("absorb_car", 32'(car_call), 32'h04);
    chk("absorb_svc", 32'(serviced), 32'h0);
    car_btn = 7'b0; door_open = 1'b0; step();

    // re-press of a latched car call
    car_btn = 7'b0001000; step(); car_btn = 7'b0; step();
    chk("cancel_set", 32'(car_call), 32'h0C);
`ifdef CALL_CANCEL_EN
    cancel_exp = 7'b0000100;
`else
    cancel_exp = 7'b0001100;
`endif
    car_btn = 7'b0001000; step(); car_btn = 7'b0; step();
    chk("cancel_car", 32'(car_call), 32'(cancel_exp));
    chk("cancel_svc", 32'(serviced), 32'h0);

    // reset mid-operation, button held through release
    reset = 1'b1; car_btn = 7'b0000001; hall_up_btn = 7'b0000010; step();
    chk("mid_rst_car", 32'(car_call), 32'h0);
    chk("mid_rst_hd", 32'(hall_dn_call), 32'h0);
    step(); reset = 1'b0; step();
    chk("held_lat", 32'(car_call), 32'h0);
    step();
    chk("held_car", 32'(car_call), 32'h01);
    chk("held_hu", 32'(hall_up_call), 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
